// File: rtl/conv_window_ctrl_pkg.sv
// Shared definitions for the sliding-window controller: FSM encoding and pixel type.
package conv_window_ctrl_pkg;

    localparam int DEFAULT_INTEGER_BITS     = 8;
    localparam int DEFAULT_FIXED_POINT_BITS = 4;
    localparam int PIXEL_W                  = DEFAULT_INTEGER_BITS + DEFAULT_FIXED_POINT_BITS;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ_ROW = 2'd1,
        ST_RETIRE   = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

endpackage

// File: rtl/conv_window_ctrl_line_buffer.sv
// One image line of storage with a single write port and a KERNEL-pixel-wide read
// starting at a column pointer (leftmost pixel in the lowest bits).
module win_line_buffer
    import conv_window_ctrl_pkg::*;
#(
    parameter int PW     = PIXEL_W,
    parameter int DEPTH  = 512,
    parameter int KERNEL = 3,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [PW-1:0]          i_wr_data,
    input  logic [AW-1:0]          i_rd_col,
    output logic [PW*KERNEL-1:0]   o_rd_data
);

    logic [PW-1:0] line_mem [DEPTH];

    // Pixel storage; contents are deliberately left untouched by reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            line_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Combinational read of KERNEL adjacent columns starting at the read pointer.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < KERNEL; k++) begin
            if (int'(i_rd_col) + k < DEPTH) begin
                o_rd_data[k*PW +: PW] = line_mem[i_rd_col + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-order pixel stream in, KERNELxKERNEL windows out. KERNEL+1 line buffers are
// used as a ring so one line can be filled while the KERNEL oldest lines are read.
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int INTEGER_BITS     = DEFAULT_INTEGER_BITS,
    parameter int FIXED_POINT_BITS = DEFAULT_FIXED_POINT_BITS,
    parameter int IMG_WIDTH        = 512,
    parameter int IMG_HEIGHT       = 512,
    parameter int KERNEL           = 3,
    localparam int PW              = INTEGER_BITS + FIXED_POINT_BITS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [PW-1:0]                 i_pixel_data,
    input  logic                          i_pixel_data_valid,
    output logic                          o_in_ready,
    output logic [PW*KERNEL*KERNEL-1:0]   o_pixel_data,
    output logic                          o_pixel_data_valid,
    input  logic                          i_pixel_data_ready,
    output logic                          o_intr,
    output logic                          o_frame_done
);

    localparam int NUM_LB   = KERNEL + 1;
    localparam int WIN_W    = PW * KERNEL * KERNEL;
    localparam int AW       = $clog2(IMG_WIDTH);
    localparam int CW       = AW + 1;
    localparam int BW       = $clog2(NUM_LB);
    localparam int LFW      = $clog2(NUM_LB + 1);
    localparam int RW       = $clog2(IMG_HEIGHT + 1);
    localparam int LAST_COL = IMG_WIDTH - KERNEL;

    state_t            state_q,      state_d;
    logic [AW-1:0]     wr_col_q,     wr_col_d;
    logic [BW-1:0]     wr_buf_q,     wr_buf_d;
    logic [BW-1:0]     rd_buf_q,     rd_buf_d;
    logic [LFW-1:0]    lines_full_q, lines_full_d;
    logic [RW-1:0]     wr_line_q,    wr_line_d;
    logic [RW-1:0]     row_cnt_q,    row_cnt_d;
    logic [CW-1:0]     rd_col_q,     rd_col_d;
    logic              out_valid_q,  out_valid_d;
    logic [WIN_W-1:0]  out_data_q,   out_data_d;
    logic              intr_q,       intr_d;
    logic              frame_done_q, frame_done_d;

    logic                  in_ready;
    logic                  in_xfer;
    logic                  line_done;
    logic                  win_accept;
    logic [KERNEL*PW-1:0]  lb_rd_data [NUM_LB];
    logic [WIN_W-1:0]      window;

    // Input is refused while every buffer holds an unretired line, during the flush
    // cycle, and once this frame's lines have all been taken in.
    assign in_ready   = !i_rst && (state_q != ST_FLUSH) && (lines_full_q < LFW'(NUM_LB))
                        && (wr_line_q < RW'(IMG_HEIGHT));
    assign in_xfer    = i_pixel_data_valid && in_ready;
    assign line_done  = in_xfer && (wr_col_q == AW'(IMG_WIDTH - 1));
    assign win_accept = out_valid_q && i_pixel_data_ready;

    for (genvar b = 0; b < NUM_LB; b++) begin : g_lb
        win_line_buffer #(
            .PW     (PW),
            .DEPTH  (IMG_WIDTH),
            .KERNEL (KERNEL)
        ) u_lb (
            .i_clk     (i_clk),
            .i_wr_en   (in_xfer && (wr_buf_q == BW'(b))),
            .i_wr_addr (wr_col_q),
            .i_wr_data (i_pixel_data),
            .i_rd_col  (rd_col_q[AW-1:0]),
            .o_rd_data (lb_rd_data[b])
        );
    end

    // Stack the KERNEL oldest unretired lines, oldest in the lowest bits.
    always_comb begin
        window = '0;
        for (int r = 0; r < KERNEL; r++) begin
            window[r*KERNEL*PW +: KERNEL*PW] = lb_rd_data[BW'((int'(rd_buf_q) + r) % NUM_LB)];
        end
    end

    // Next-state logic: write pointer, line occupancy, row sequencing and output register.
    always_comb begin
        state_d      = state_q;
        wr_col_d     = wr_col_q;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        lines_full_d = lines_full_q;
        wr_line_d    = wr_line_q;
        row_cnt_d    = row_cnt_q;
        rd_col_d     = rd_col_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        intr_d       = 1'b0;
        frame_done_d = 1'b0;

        if (in_xfer) begin
            if (line_done) begin
                wr_col_d  = '0;
                wr_buf_d  = (wr_buf_q == BW'(NUM_LB - 1)) ? '0 : wr_buf_q + 1'b1;
                wr_line_d = wr_line_q + 1'b1;
            end else begin
                wr_col_d  = wr_col_q + 1'b1;
            end
        end

        if (line_done && (state_q != ST_RETIRE)) begin
            lines_full_d = lines_full_q + 1'b1;
        end else if (!line_done && (state_q == ST_RETIRE)) begin
            lines_full_d = lines_full_q - 1'b1;
        end

        if (win_accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (lines_full_q >= LFW'(KERNEL)) begin
                    state_d  = ST_READ_ROW;
                    rd_col_d = '0;
                end
            end
            ST_READ_ROW: begin
                if (rd_col_q <= CW'(LAST_COL)) begin
                    if (!out_valid_q || i_pixel_data_ready) begin
                        out_data_d  = window;
                        out_valid_d = 1'b1;
                        rd_col_d    = rd_col_q + 1'b1;
                    end
                end else if (win_accept) begin
                    state_d = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                rd_buf_d  = (rd_buf_q == BW'(NUM_LB - 1)) ? '0 : rd_buf_q + 1'b1;
                row_cnt_d = row_cnt_q + 1'b1;
                intr_d    = 1'b1;
                if (row_cnt_q == RW'(IMG_HEIGHT - KERNEL)) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_FLUSH;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                wr_col_d     = '0;
                wr_buf_d     = '0;
                rd_buf_d     = '0;
                lines_full_d = '0;
                wr_line_d    = '0;
                row_cnt_d    = '0;
                rd_col_d     = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All controller state and registered outputs, with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wr_col_q     <= '0;
            wr_buf_q     <= '0;
            rd_buf_q     <= '0;
            lines_full_q <= '0;
            wr_line_q    <= '0;
            row_cnt_q    <= '0;
            rd_col_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            intr_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_col_q     <= wr_col_d;
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
            lines_full_q <= lines_full_d;
            wr_line_q    <= wr_line_d;
            row_cnt_q    <= row_cnt_d;
            rd_col_q     <= rd_col_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            intr_q       <= intr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_in_ready         = in_ready;
    assign o_pixel_data       = out_data_q;
    assign o_pixel_data_valid = out_valid_q;
    assign o_intr             = intr_q;
    assign o_frame_done       = frame_done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on an 8x6 image with a 3x3 kernel; expected
// windows are queued as each input line completes and popped as windows are accepted.
module tb_conv_window_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int K   = 3;
    localparam int PW  = 12;
    localparam int WIN = PW * K * K;

    logic           clk = 1'b0;
    logic           rst;
    logic [PW-1:0]  pix;
    logic           pix_valid;
    logic           in_ready;
    logic [WIN-1:0] win;
    logic           win_valid;
    logic           win_ready;
    logic           intr;
    logic           frame_done;

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .INTEGER_BITS     (8),
        .FIXED_POINT_BITS (4),
        .IMG_WIDTH        (W),
        .IMG_HEIGHT       (H),
        .KERNEL           (K)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .o_in_ready         (in_ready),
        .o_pixel_data       (win),
        .o_pixel_data_valid (win_valid),
        .i_pixel_data_ready (win_ready),
        .o_intr             (intr),
        .o_frame_done       (frame_done)
    );

    int checks = 0;
    int errors = 0;

    logic [WIN-1:0] sb_q [$];
    logic [WIN-1:0] mon_exp;
    logic [WIN-1:0] first_win;
    logic [WIN-1:0] second_first_win;
    logic [WIN-1:0] first_exp;
    logic [WIN-1:0] prev_data;
    logic           prev_stall = 1'b0;

    int   src_line = 0;
    int   src_col = 0;
    int   src_remaining = 0;
    int   src_sent = 0;
    logic src_en = 1'b0;

    logic last_valid;
    logic last_intr;
    logic last_in_ready;
    logic ready_seen;

    int win_cnt = 0;
    int intr_cnt = 0;
    int frame_cnt = 0;
    int guard;

    task automatic checkOutput(input string tag, input logic [WIN-1:0] obs, input logic [WIN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN-1:0] expWindow(input int row, input int col);
        logic [WIN-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                w[(r*K+k)*PW +: PW] = PW'(16*(row+r) + col + k);
            end
        end
        return w;
    endfunction

    // One clock per iteration: drive the source, sample at negedge, advance on transfer.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pix_valid = src_en && (src_remaining > 0);
            pix       = pix_valid ? PW'(16*src_line + src_col) : '0;
            @(negedge clk);
            last_valid    = win_valid;
            last_intr     = intr;
            last_in_ready = in_ready;
            if (pix_valid && in_ready) begin
                if (src_col == W-1) begin
                    if (src_line >= K-1) begin
                        for (int c = 0; c <= W-K; c++) sb_q.push_back(expWindow(src_line-K+1, c));
                    end
                    src_col  = 0;
                    src_line = (src_line == H-1) ? 0 : src_line + 1;
                end else begin
                    src_col++;
                end
                src_remaining--;
                src_sent++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runUntilSent(input int n, input string tag);
        guard = 0;
        while (src_sent < n && guard < 2000) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput(tag, WIN'(src_sent), WIN'(n));
    endtask

    task automatic runUntilWindows(input int n, input string tag);
        guard = 0;
        while (win_cnt < n && guard < 2000) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput(tag, WIN'(win_cnt >= n), WIN'(1));
    endtask

    task automatic waitFrames(input int n, input string tag);
        guard = 0;
        while (frame_cnt < n && guard < 2000) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput(tag, WIN'(frame_cnt), WIN'(n));
    endtask

    task automatic clearCounters();
        win_cnt   = 0;
        intr_cnt  = 0;
        frame_cnt = 0;
        src_sent  = 0;
    endtask

    // Monitor: scoreboard pops on acceptance, stall stability, pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", WIN'(win_valid), WIN'(1));
                checkOutput("hold_data", win, prev_data);
            end
            if (win_valid && win_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", WIN'(sb_q.size()), WIN'(1));
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("window", win, mon_exp);
                end
                if (win_cnt == 0)  first_win = win;
                if (win_cnt == 24) second_first_win = win;
                win_cnt++;
            end
            if (intr)       intr_cnt++;
            if (frame_done) frame_cnt++;
            prev_stall = win_valid && !win_ready;
            prev_data  = win;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        first_exp = {12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010, 12'h002, 12'h001, 12'h000};
        rst       = 1'b1;
        pix       = '0;
        pix_valid = 1'b0;
        win_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_in_ready", WIN'(in_ready), WIN'(0));
        checkOutput("rst_valid", WIN'(win_valid), WIN'(0));
        checkOutput("rst_data", win, '0);
        checkOutput("rst_intr", WIN'(intr), WIN'(0));
        checkOutput("rst_frame_done", WIN'(frame_done), WIN'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", WIN'(in_ready), WIN'(1));
        @(posedge clk);
        #1;

        // Two back-to-back frames at full throughput, with first-window latency
        clearCounters();
        src_en        = 1'b1;
        src_remaining = 96;
        runUntilSent(24, "a_sent_3_lines");
        applyStimulus(1);
        checkOutput("a_lat_c1", WIN'(last_valid), WIN'(0));
        applyStimulus(1);
        checkOutput("a_lat_c2", WIN'(last_valid), WIN'(0));
        applyStimulus(1);
        checkOutput("a_lat_c3", WIN'(last_valid), WIN'(1));
        waitFrames(2, "a_frames");
        checkOutput("a_intr_cnt", WIN'(intr_cnt), WIN'(8));
        checkOutput("a_win_cnt", WIN'(win_cnt), WIN'(48));
        checkOutput("a_first_win", first_win, first_exp);
        checkOutput("a_second_first_win", second_first_win, first_exp);
        checkOutput("a_sb_empty", WIN'(sb_q.size()), WIN'(0));

        // Line completes in the retire cycle, then a 5-cycle downstream stall mid-row
        clearCounters();
        src_remaining = 48;
        runUntilSent(24, "b_sent_3_lines");
        src_en = 1'b0;
        applyStimulus(1);
        src_en = 1'b1;
        runUntilSent(32, "b_sent_4_lines");
        src_en = 1'b0;
        applyStimulus(1);
        checkOutput("b_intr_row0", WIN'(last_intr), WIN'(1));
        checkOutput("b_in_ready_row0", WIN'(last_in_ready), WIN'(1));
        checkOutput("b_gap_c1", WIN'(last_valid), WIN'(0));
        applyStimulus(1);
        checkOutput("b_gap_c2", WIN'(last_valid), WIN'(0));
        applyStimulus(1);
        checkOutput("b_row1_start", WIN'(last_valid), WIN'(1));
        src_en = 1'b1;
        runUntilWindows(9, "b_reach_stall_point");
        win_ready = 1'b0;
        applyStimulus(5);
        win_ready = 1'b1;
        waitFrames(1, "b_frames");
        checkOutput("b_intr_cnt", WIN'(intr_cnt), WIN'(4));
        checkOutput("b_win_cnt", WIN'(win_cnt), WIN'(24));
        checkOutput("b_sb_empty", WIN'(sb_q.size()), WIN'(0));

        // Reset in the middle of row 1
        clearCounters();
        src_remaining = 48;
        runUntilWindows(9, "c_reach_reset_point");
        rst           = 1'b1;
        src_en        = 1'b0;
        src_remaining = 0;
        src_line      = 0;
        src_col       = 0;
        sb_q.delete();
        applyStimulus(1);
        @(negedge clk);
        checkOutput("c_rst_valid", WIN'(win_valid), WIN'(0));
        checkOutput("c_rst_data", win, '0);
        checkOutput("c_rst_intr", WIN'(intr), WIN'(0));
        checkOutput("c_rst_in_ready", WIN'(in_ready), WIN'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh frame after the mid-frame reset
        clearCounters();
        src_en        = 1'b1;
        src_remaining = 48;
        waitFrames(1, "d_frames");
        checkOutput("d_intr_cnt", WIN'(intr_cnt), WIN'(4));
        checkOutput("d_win_cnt", WIN'(win_cnt), WIN'(24));
        checkOutput("d_first_win", first_win, first_exp);
        checkOutput("d_sb_empty", WIN'(sb_q.size()), WIN'(0));

        // Downstream blocked: input must stall once all line buffers are full
        clearCounters();
        win_ready     = 1'b0;
        src_remaining = 48;
        applyStimulus(40);
        checkOutput("e_sent_blocked", WIN'(src_sent), WIN'(32));
        checkOutput("e_in_ready_blocked", WIN'(last_in_ready), WIN'(0));
        win_ready = 1'b1;
        guard = 0;
        last_intr = 1'b0;
        while (!last_intr && guard < 200) begin
            applyStimulus(1);
            guard++;
        end
        ready_seen = last_in_ready;
        applyStimulus(1);
        ready_seen = ready_seen | last_in_ready;
        checkOutput("e_in_ready_after_retire", WIN'(ready_seen), WIN'(1));
        waitFrames(1, "e_frames");
        checkOutput("e_intr_cnt", WIN'(intr_cnt), WIN'(4));
        checkOutput("e_win_cnt", WIN'(win_cnt), WIN'(24));
        checkOutput("e_sb_empty", WIN'(sb_q.size()), WIN'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter INTEGER_BITS, default 8, integer bits of a fixed-point pixel.
REQ-002 Parameter FIXED_POINT_BITS, default 4, fractional bits; PW = INTEGER_BITS+FIXED_POINT_BITS.
REQ-003 Parameter IMG_WIDTH, default 512, pixels per line, legal range 4..1024.
REQ-004 Parameter IMG_HEIGHT, default 512, lines per frame, range KERNEL..1024.
REQ-005 Parameter KERNEL, default 3, window edge, legal values 3 or 5; NUM_LB = KERNEL+1, derived.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 i_clk  in  1  the only clock; all state changes on its rising edge.
REQ-008 i_rst  in  1  synchronous, active-high reset.
REQ-009 i_pixel_data  in  PW  raster-order input pixel.
REQ-010 i_pixel_data_valid  in  1  input pixel present.
REQ-011 o_in_ready  out  1  block accepts i_pixel_data this cycle.
REQ-012 o_pixel_data  out  PW*KERNEL*KERNEL  window; row-major, oldest line at LSBs, leftmost pixel lowest in each row.
REQ-013 o_pixel_data_valid  out  1  window present; held with stable data until accepted.
REQ-014 i_pixel_data_ready  in  1  downstream accepts window.
REQ-015 o_intr  out  1  one-cycle pulse per completed output row.
REQ-016 o_frame_done  out  1  one-cycle pulse when the frame's last window is accepted.

Function
REQ-017 Input transfer SHALL occur only when i_pixel_data_valid and o_in_ready are both 1.
REQ-018 Write column pointer SHALL wrap IMG_WIDTH-1 -> 0 on transfer; on wrap, write-buffer index SHALL advance modulo NUM_LB and lines_full SHALL increment.
REQ-019 lines_full (0..NUM_LB) SHALL count completed lines not yet retired; o_in_ready = (lines_full < NUM_LB) and not in FLUSH.
REQ-020 FSM states IDLE, READ_ROW, RETIRE, FLUSH; reset state IDLE.
REQ-021 IDLE -> READ_ROW when lines_full >= KERNEL.
REQ-022 READ_ROW SHALL emit exactly IMG_WIDTH-KERNEL+1 windows; window c holds columns c..c+KERNEL-1 of the KERNEL oldest unretired lines.
REQ-023 Output register SHALL load a new window when empty or accepted in that cycle; full throughput one window per cycle when i_pixel_data_ready = 1.
REQ-024 Latency: first window SHALL be valid exactly 2 cycles after the IDLE -> READ_ROW transition condition is sampled true.
REQ-025 READ_ROW -> RETIRE on acceptance of the row's last window; RETIRE SHALL decrement lines_full by 1, advance read-buffer index modulo NUM_LB, pulse o_intr, then go to IDLE.
REQ-026 Simultaneous line-complete write and RETIRE SHALL leave lines_full unchanged.
REQ-027 After the IMG_HEIGHT-KERNEL+1-th row retires, o_frame_done SHALL pulse with o_intr, FSM SHALL enter FLUSH for one cycle clearing lines_full, both indices and pointers, then return to IDLE.
REQ-028 o_pixel_data_valid SHALL never drop, and o_pixel_data SHALL never change, while i_pixel_data_ready = 0.
REQ-029 No arithmetic on pixel values; data passes bit-exact.

Reset
REQ-030 On i_rst: o_in_ready 0 during reset, 1 the cycle after; o_pixel_data_valid, o_intr, o_frame_done 0; o_pixel_data all zero.
REQ-031 On i_rst: counters, pointers, indices, lines_full, row count cleared; FSM to IDLE.
REQ-032 Reset mid-row or mid-frame SHALL discard all buffered pixels and in-flight windows; line-buffer storage contents need not be cleared.

Structure
REQ-033 Shared package SHALL hold FSM state encoding and a PW-width pixel typedef.
REQ-034 One sub-module, win_line_buffer: depth IMG_WIDTH, one write port, KERNEL-wide read at a column pointer; instantiated NUM_LB times via generate.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL=3, PW=12, pixel = 16*row+col)
REQ-035 Stream 48 pixels, ready always 1 -> 4 rows x 6 windows; first window columns 0..2 = {0x000,0x001,0x002,0x010,0x011,0x012,0x020,0x021,0x022}; 4 o_intr pulses, 1 o_frame_done.
REQ-036 Hold i_pixel_data_ready=0 for 5 cycles mid-row -> data/valid frozen; no window lost or duplicated.
REQ-037 Source always valid, ready=0 -> after 32 pixels o_in_ready=0; resuming ready -> o_in_ready=1 within 2 cycles of RETIRE.
REQ-038 Write completes line 4 in RETIRE cycle -> lines_full unchanged, next row starts correctly.
REQ-039 Assert i_rst at window 3 of row 1 -> outputs zero next cycle; fresh frame afterwards gives REQ-035 results.
REQ-040 Two back-to-back frames -> second frame's first window = first frame's; no stale lines.
